// File: rtl/sum_sched_pkg.sv
// Shared state type, width helpers and round-robin pick function for sum_sched.
// Build option: define SUM_SCHED_SAT_EN for a saturating accumulator (default wraps).
package sum_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int MAX_REQ   = 32;
    localparam int MAX_REQ_W = $clog2(MAX_REQ);

    function automatic int sum_width(input int inputNum, input int inputWidth);
        return inputWidth + $clog2(inputNum);
    endfunction

    function automatic int acc_width(input int sumWidth, input int maxBeats);
        return sumWidth + $clog2(maxBeats);
    endfunction

    function automatic int beat_width(input int maxBeats);
        return $clog2(maxBeats) + 1;
    endfunction

    // Scan ptr+1, ptr+2, ... wrapping at numReq; returns -1 when nobody requests.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int ptr, input int numReq);
        int pick;
        int idx;
        pick = -1;
        for (int k = 1; k <= numReq; k++) begin
            idx = (ptr + k) % numReq;
            if (pick < 0 && req[idx[MAX_REQ_W-1:0]]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sum_sched_add.sv
// Combinational unsigned adder tree: sums INPUT_NUM elements of INPUT_WIDTH bits.
module add
    import sum_sched_pkg::*;
#(
    parameter int  INPUT_NUM   = 8,
    parameter int  INPUT_WIDTH = 8,
    localparam int SUM_WIDTH   = sum_width(INPUT_NUM, INPUT_WIDTH)
) (
    input  logic [INPUT_NUM*INPUT_WIDTH-1:0] dat_i,
    output logic [SUM_WIDTH-1:0]             sum_o
);

    always_comb begin
        sum_o = '0;
        for (int i = 0; i < INPUT_NUM; i++) begin
            sum_o = sum_o + SUM_WIDTH'(dat_i[i*INPUT_WIDTH +: INPUT_WIDTH]);
        end
    end

endmodule

// File: rtl/sum_sched_rr_arbiter.sv
// Round-robin arbiter: request vector plus last-served pointer to one-hot grant and index.
module rr_arbiter
    import sum_sched_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic [NUM_REQ-1:0] grant_o
);

    logic [MAX_REQ-1:0] reqExt;
    int                 pick;

    always_comb begin
        reqExt  = MAX_REQ'(req_i);
        pick    = rr_pick(reqExt, int'(ptr_i), NUM_REQ);
        valid_o = (pick >= 0);
        idx_o   = valid_o ? IDX_W'(pick) : '0;
        grant_o = valid_o ? (NUM_REQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/sum_sched.sv
// Frame accumulator sharing one add between NUM_REQ requesters, granted round-robin per frame.
// Build option: SUM_SCHED_SAT_EN clamps the accumulator on overflow instead of wrapping.
module sum_sched
    import sum_sched_pkg::*;
#(
    parameter int  NUM_REQ     = 4,
    parameter int  INPUT_NUM   = 8,
    parameter int  INPUT_WIDTH = 8,
    parameter int  MAX_BEATS   = 16,
    parameter int  ACC_WIDTH   = acc_width(sum_width(INPUT_NUM, INPUT_WIDTH), MAX_BEATS),
    localparam int SUM_WIDTH   = sum_width(INPUT_NUM, INPUT_WIDTH),
    localparam int ID_W        = $clog2(NUM_REQ),
    localparam int BEAT_W      = beat_width(MAX_BEATS),
    localparam int VEC_W       = INPUT_NUM * INPUT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_last,
    input  logic [NUM_REQ*VEC_W-1:0] req_dat,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_WIDTH-1:0]     out_dat,
    output logic [ID_W-1:0]          out_id,
    output logic [BEAT_W-1:0]        out_beats,
    output logic                     out_ovf
);

    state_e               state_q, state_d;
    logic [ID_W-1:0]      grant_q, grant_d;
    logic [NUM_REQ-1:0]   grantHot_q, grantHot_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [BEAT_W-1:0]    beats_q, beats_d;
    logic                 ovf_q, ovf_d;
    logic                 outValid_q, outValid_d;
    logic [ACC_WIDTH-1:0] outDat_q, outDat_d;
    logic [ID_W-1:0]      outId_q, outId_d;
    logic [BEAT_W-1:0]    outBeats_q, outBeats_d;
    logic                 outOvf_q, outOvf_d;

    logic                 arbValid;
    logic [ID_W-1:0]      arbIdx;
    logic [NUM_REQ-1:0]   arbHot;
    logic [VEC_W-1:0]     vecSel;
    logic [SUM_WIDTH-1:0] beatSum;
    logic [ACC_WIDTH:0]   accSum;
    logic [ACC_WIDTH-1:0] accStep;
    logic [BEAT_W-1:0]    beatsInc;
    logic                 carry;
    logic                 handshake;
    logic                 frameEnd;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .valid_o (arbValid),
        .idx_o   (arbIdx),
        .grant_o (arbHot)
    );

    add #(.INPUT_NUM(INPUT_NUM), .INPUT_WIDTH(INPUT_WIDTH)) u_add (
        .dat_i (vecSel),
        .sum_o (beatSum)
    );

    // The extra accumulator bit exposes the carry used for the overflow flag.
    always_comb begin
        vecSel    = req_dat[int'(grant_q)*VEC_W +: VEC_W];
        accSum    = {1'b0, acc_q} + (ACC_WIDTH+1)'(beatSum);
        carry     = accSum[ACC_WIDTH];
        beatsInc  = beats_q + 1'b1;
        handshake = (state_q == RUN) && req_valid[grant_q];
        frameEnd  = handshake && (req_last[grant_q] || beatsInc == BEAT_W'(MAX_BEATS));
`ifdef SUM_SCHED_SAT_EN
        accStep   = (ovf_q || carry) ? '1 : accSum[ACC_WIDTH-1:0];
`else
        accStep   = accSum[ACC_WIDTH-1:0];
`endif
        req_ready = (state_q == RUN) ? grantHot_q : '0;
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grantHot_d = grantHot_q;
        ptr_d      = ptr_q;
        acc_d      = acc_q;
        beats_d    = beats_q;
        ovf_d      = ovf_q;
        outValid_d = outValid_q;
        outDat_d   = outDat_q;
        outId_d    = outId_q;
        outBeats_d = outBeats_q;
        outOvf_d   = outOvf_q;
        case (state_q)
            IDLE: begin
                if (arbValid) begin
                    grant_d    = arbIdx;
                    grantHot_d = arbHot;
                    acc_d      = '0;
                    beats_d    = '0;
                    ovf_d      = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (handshake) begin
                    acc_d   = accStep;
                    beats_d = beatsInc;
                    ovf_d   = ovf_q | carry;
                    if (frameEnd) begin
                        state_d    = HOLD;
                        outValid_d = 1'b1;
                        outDat_d   = accStep;
                        outId_d    = grant_q;
                        outBeats_d = beatsInc;
                        outOvf_d   = ovf_q | carry;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    outValid_d = 1'b0;
                    ptr_d      = grant_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset parks the pointer on the last requester so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grantHot_q <= '0;
            ptr_q      <= ID_W'(NUM_REQ - 1);
            acc_q      <= '0;
            beats_q    <= '0;
            ovf_q      <= 1'b0;
            outValid_q <= 1'b0;
            outDat_q   <= '0;
            outId_q    <= '0;
            outBeats_q <= '0;
            outOvf_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grantHot_q <= grantHot_d;
            ptr_q      <= ptr_d;
            acc_q      <= acc_d;
            beats_q    <= beats_d;
            ovf_q      <= ovf_d;
            outValid_q <= outValid_d;
            outDat_q   <= outDat_d;
            outId_q    <= outId_d;
            outBeats_q <= outBeats_d;
            outOvf_q   <= outOvf_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_dat   = outDat_q;
    assign out_id    = outId_q;
    assign out_beats = outBeats_q;
    assign out_ovf   = outOvf_q;

endmodule
